// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational
// alu_unit between two requesters, with tagged, stallable results.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_AND = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_SLT = OPW'(4'b1000);

  state_t           state;
  logic             rr_ptr;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic             grant0;
  logic             grant1;
  logic             op_legal;

  // One-hot grant, offered only while idle
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        (req0_valid && req1_valid): begin
          grant0 = ~rr_ptr;
          grant1 = rr_ptr;
        end
        (req0_valid && !req1_valid): grant0 = 1'b1;
        (!req0_valid && req1_valid): grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;

  // Opcodes the ALU actually implements
  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLT: op_legal = 1'b1;
      default:       op_legal = 1'b0;
    endcase
  end

  // Sequencer: accept, run ALU for a cycle, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q    <= grant1 ? req1_a : req0_a;
            b_q    <= grant1 ? req1_b : req0_b;
            op_q   <= grant1 ? req1_op : req0_op;
            id_q   <= grant1;
            rr_ptr <= grant0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_id     <= id_q;
          rsp_err    <= ~op_legal;
          rsp_result <= op_legal ? alu_result : '0;
          rsp_zero   <= op_legal & alu_zero;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with a stub ALU,
// a transaction-level arbiter model and randomized traffic.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic [3:0]  req0_op = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic [3:0]  req1_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Stub alu_unit; unimplemented codes return junk
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a + ~alu_b + 32'd1;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b1000: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = alu_a ^ alu_b ^ 32'hdead_beef;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic rsp_t model(input logic id,
                                 input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (op)
      4'd0:    r.res = a + b;
      4'd1:    r.res = a - b;
      4'd2:    r.res = a & b;
      4'd3:    r.res = a | b;
      4'd8:    r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        r.res = 32'd0;
        r.err = 1'b1;
      end
    endcase
    r.zero = !r.err && (r.res == 32'd0);
    return r;
  endfunction

  // Arbiter model: 0 idle, 1 executing, 2 responding
  int   phase = 0;
  logic ptr = 1'b0;
  logic g0, g1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_flags",
          64'({rsp_valid, rsp_id, rsp_zero, rsp_err,
               req0_ready, req1_ready}), 64'd0);
      chk("rst_result", 64'(rsp_result), 64'd0);
      chk("rst_alu", 64'({alu_a, alu_b} | 64'(alu_ctrl)), 64'd0);
      phase = 0;
      ptr   = 1'b0;
      exp_q.delete();
    end else begin
      g0 = (phase == 0) && req0_valid && (!req1_valid || !ptr);
      g1 = (phase == 0) && req1_valid && (!req0_valid || ptr);
      chk("readies", 64'({req0_ready, req1_ready}), 64'({g0, g1}));
      chk("rsp_valid", 64'(rsp_valid), 64'(phase == 2));
      case (phase)
        0: if (g0 || g1) begin
          if (g0) exp_q.push_back(model(1'b0, req0_op, req0_a, req0_b));
          else    exp_q.push_back(model(1'b1, req1_op, req1_a, req1_b));
          ptr   = g0;
          phase = 1;
        end
        1: phase = 2;
        default: if (rsp_ready) phase = 0;
      endcase
    end
  end

  // Monitor: compare presented response with scoreboard head
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        chk("rsp", 64'({rsp_id, rsp_result, rsp_zero, rsp_err}),
            64'(exp_q[0]));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    logic rdy;
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    forever begin
      @(negedge clk);
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'(id), 64'hffff);
        break;
      end
    end
    sync();
    if (id == 0) begin
      req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
      req0_op = 4'($urandom);
    end else begin
      req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom;
      req1_op = 4'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 || rsp_valid) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        chk("idle_timeout", 64'(exp_q.size()), 64'd0);
        break;
      end
    end
    sync();
  endtask

  function automatic logic [3:0] pick_op();
    logic [3:0] legal [5];
    logic [3:0] o;
    legal[0] = 4'd0; legal[1] = 4'd1; legal[2] = 4'd2;
    legal[3] = 4'd3; legal[4] = 4'd8;
    if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 4)];
    o = 4'($urandom_range(4, 15));
    if (o == 4'd8) o = 4'd9;
    return o;
  endfunction

  function automatic logic [31:0] pick_val();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  task automatic rand_req(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) sync();
      send(id, pick_op(), pick_val(), pick_val());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) sync();
    rst_n = 1'b1;
  endtask

  bit rand_done = 1'b0;

  initial begin
    #1;
    do_reset();
    // contention right after reset: req0 first
    fork
      send(0, 4'b1000, 32'd5, 32'd10);
      send(1, 4'b0000, 32'd1, 32'd2);
    join
    wait_idle();
    send(0, 4'b0000, 32'd10, 32'd5);
    wait_idle();
    send(1, 4'b0001, 32'd10, 32'd10);
    send(0, 4'b0010, 32'd10, 32'd5);
    send(0, 4'b0011, 32'd10, 32'd5);
    send(0, 4'b1111, 32'd7, 32'd7);
    wait_idle();
    // backpressure with a competing request pending
    fork
      begin
        rsp_ready = 1'b0;
        send(0, 4'b0000, 32'hffff_ffff, 32'd1);
        repeat (6) sync();
        rsp_ready = 1'b1;
      end
      begin
        sync();
        send(1, 4'b0011, 32'h00f0, 32'h0f00);
      end
    join
    wait_idle();
    // abort during EXEC
    send(1, 4'b0000, 32'd3, 32'd4);
    #2;
    do_reset();
    fork
      send(0, 4'b0001, 32'd9, 32'd4);
      send(1, 4'b0000, 32'd20, 32'd22);
    join
    wait_idle();
    // randomized traffic with random backpressure
    fork
      begin
        fork
          rand_req(0, 40);
          rand_req(1, 40);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          sync();
          rsp_ready = ($urandom_range(0, 9) < 7);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester round-robin arbiter that shares the single 32-bit `alu_unit` between independent requesters, for example the main execute path and an address/branch-compare helper. It accepts one operation at a time over a valid/ready handshake and latches the operands into registers that drive the ALU. It captures the ALU result and returns it, tagged with the requester ID, over a backpressurable response channel. It also flags opcodes the ALU does not implement.

## Interface
- `WIDTH`, default 32: operand/result width.
- `OPW`, default 4: ALU control width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_a`, `req0_b` in WIDTH: requester 0 operands.
- `req0_op` in OPW: requester 0 ALU control code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `rsp_valid` out 1: a result is presented.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_id` out 1: requester that issued the result.
- `rsp_result` out WIDTH: ALU_out captured.
- `rsp_zero` out 1: zero flag captured.
- `rsp_err` out 1: opcode was illegal.
- `alu_a`, `alu_b` out WIDTH: to `alu_unit` A/B.
- `alu_ctrl` out OPW: to `alu_unit` control_in.
- `alu_result` in WIDTH: from `alu_unit` ALU_out.
- `alu_zero` in 1: from `alu_unit` zero.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `reqN_valid` is high, grant exactly one requester. `reqN_ready` is high combinationally for the granted requester only.
  - On the clock edge, latch a, b, op and id into the operand registers, then go to EXEC.
  - With no valid request, stay in IDLE and keep both readies low.
- **Grant rule:**
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester selected by the priority pointer `rr_ptr`.
  - After a grant to requester i, set `rr_ptr` to the other requester (!i). `rr_ptr` resets to 0.
- **EXEC:**
  - The operand registers drive `alu_a`/`alu_b`/`alu_ctrl`.
  - At the end of the cycle, capture `alu_result`/`alu_zero` into the response registers and go to RESP.
- **Legal opcodes:** 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 1000 SLT. Any other code stores `rsp_err`=1, `rsp_result`=0, `rsp_zero`=0, and ignores the ALU output.
- **RESP:**
  - `rsp_valid`=1, with `rsp_id`, `rsp_result`, `rsp_zero` and `rsp_err` held stable.
  - When `rsp_ready`=1, go to IDLE.
  - While `rsp_ready`=0, hold all response outputs unchanged.
  - No request is accepted in EXEC or RESP; both readies are low.
- **ALU port driving:** `alu_a`/`alu_b`/`alu_ctrl` always come from the operand registers, including in IDLE, where the last values persist.
- **Width:** the ALU is purely combinational. The arbiter performs no arithmetic and does no width conversion.

## Timing
- **Reset values (immediate on `rst_n` low):**
  - state = IDLE, `rr_ptr` = 0.
  - All operand and response registers = 0.
  - `rsp_valid` = 0, `req0_ready` = `req1_ready` = 0 (no valid requests during reset).
- **Latency:** handshake in cycle T, EXEC in T+1, `rsp_valid` high in T+2.
- **Throughput:** at most one operation per 3 cycles.
- **Back-to-back:** the response handshake in cycle R is followed by the earliest next accept in R+1.
- **Simultaneous valid:** exactly one ready goes high. Requests from both requesters held continuously are served alternately: 0, 1, 0, 1…
- **Requester behaviour:** a requester must hold valid and its operands stable until it sees ready. Operands are sampled only on the handshake edge.
- **Reset mid-operation:** asynchronous abort. The in-flight operation is discarded, no response is produced, and `rr_ptr` returns to 0.
- **Outputs:** all outputs except `reqN_ready` are registered-only. Readies are a function of state, `rr_ptr` and the valids.

## Test plan
- **Single request:** req0 ADD a=10, b=5 with no contention. Expect `req0_ready` high in T, `rsp_valid` in T+2, `rsp_id`=0, `rsp_result`=15, `rsp_zero`=0, `rsp_err`=0.
- **SUB to zero:** req1 SUB a=10, b=10. Expect `rsp_id`=1, `rsp_result`=0, `rsp_zero`=1. Then req0 AND 10&5 gives 0 with zero=1, and OR 10|5 gives 15.
- **Contention:** both valid immediately after reset, req0 SLT 5,10 and req1 ADD 1,2. Expect req0 served first (result 1), then req1 (result 3). Each `reqN_ready` pulses exactly once.
- **Illegal opcode:** req0 op=4'b1111, a=7, b=7. Expect `rsp_err`=1, `rsp_result`=0, `rsp_zero`=0, with state returning to IDLE normally.
- **Backpressure:** `rsp_ready` held low for 5 cycles during RESP. Expect the response to stay stable, both readies low throughout, and completion on the first `rsp_ready`=1.
- **Reset abort:** assert `rst_n` low during EXEC of req1 ADD 3,4. Expect `rsp_valid` to stay 0 and all outputs to return to 0. After release, a contended request grants req0 first.
